// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-memory req/ack sequencer, branch/jump redirect and MEM/WB register; WB valid
// 1 cycle after an ALU op, >=3 cycles after a memop; stall holds upstream while an access is open.
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_pc_plus4,
    input  logic [31:0] MEM_npc,
    input  logic [31:0] MEM_busB,
    input  logic [4:0]  MEM_Rw,
    input  logic [31:0] MEM_ALUresult,
    input  logic        MEM_zero,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemWrite,
    input  logic        MEM_RegWrite,
    input  logic        MEM_Branch,
    input  logic        MEM_nBranch,
    input  logic        MEM_BGEZ,
    input  logic        MEM_BGTZ,
    input  logic        MEM_BLEZ,
    input  logic        MEM_BLTZ,
    input  logic        MEM_lb,
    input  logic        MEM_lbu,
    input  logic        MEM_sb,
    input  logic        MEM_jal,
    input  logic        MEM_jmp,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        bus_err,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_Rw,
    output logic [31:0] WB_wdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            aborted;
    logic [1:0]      lane;
    logic [31:0]     rdata_q;
    logic            memop;
    logic            timeout;
    logic            taken;
    logic            sgn, is_zero;
    logic [7:0]      ld_byte;
    logic [31:0]     load_data;
    logic [31:0]     wb_data;

    assign memop   = MEM_MemtoReg | MEM_MemWrite;
    // Ack wins over timeout when both land in the last allowed wait cycle
    assign timeout = (state == S_WAIT) && !dm_ack && (cnt == CW'(MAX_WAIT - 1));

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        dm_req    = 1'b0;
        case (state)
            S_IDLE: begin
                if (memop) begin
                    stall     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                stall  = 1'b1;
                dm_req = 1'b1;
                if (dm_ack || timeout) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sgn     = MEM_ALUresult[31];
    assign is_zero = (MEM_ALUresult == 32'd0);
    assign taken   = (MEM_Branch & MEM_zero) | (MEM_nBranch & ~MEM_zero)
                   | (MEM_BGEZ & ~sgn) | (MEM_BGTZ & ~sgn & ~is_zero)
                   | (MEM_BLEZ & (sgn | is_zero)) | (MEM_BLTZ & sgn)
                   | MEM_jmp | MEM_jal;
    assign redirect    = taken & ~stall;
    assign redirect_pc = MEM_npc;

    assign ld_byte   = rdata_q[{lane, 3'b000} +: 8];
    assign load_data = MEM_lb  ? {{24{ld_byte[7]}}, ld_byte} :
                       MEM_lbu ? {24'd0, ld_byte} : rdata_q;
    assign wb_data   = MEM_jal      ? MEM_pc_plus4 :
                       MEM_MemtoReg ? load_data    : MEM_ALUresult;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            aborted     <= 1'b0;
            lane        <= 2'd0;
            rdata_q     <= 32'd0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'd0;
            dm_be       <= 4'd0;
            dm_wdata    <= 32'd0;
            bus_err     <= 1'b0;
            WB_RegWrite <= 1'b0;
            WB_Rw       <= 5'd0;
            WB_wdata    <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (memop) begin
                        cnt         <= '0;
                        aborted     <= 1'b0;
                        lane        <= MEM_ALUresult[1:0];
                        dm_addr     <= {MEM_ALUresult[31:2], 2'b00};
                        dm_we       <= MEM_MemWrite;
                        dm_be       <= (MEM_MemWrite && MEM_sb) ? (4'b0001 << MEM_ALUresult[1:0]) : 4'b1111;
                        dm_wdata    <= (MEM_MemWrite && MEM_sb) ? {4{MEM_busB[7:0]}} : MEM_busB;
                        WB_RegWrite <= 1'b0;
                    end else begin
                        WB_RegWrite <= MEM_RegWrite;
                        WB_Rw       <= MEM_Rw;
                        WB_wdata    <= wb_data;
                    end
                end
                S_WAIT: begin
                    if (cnt != CW'(MAX_WAIT)) cnt <= cnt + CW'(1);
                    if (dm_ack) begin
                        rdata_q <= dm_rdata;
                    end else if (timeout) begin
                        bus_err <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                S_DONE: begin
                    // EX/MEM is still frozen on the memop here, so MEM_* describe it
                    WB_RegWrite <= MEM_RegWrite & ~aborted;
                    WB_Rw       <= MEM_Rw;
                    WB_wdata    <= wb_data;
                end
                default: ;
            endcase
        end
    end

endmodule
